// File: rtl/branch_resolve_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_pkg
// Shared constants for the branch resolution unit:
//   - branch opcode encodings (br_op)
//   - 2-bit FSM state encoding
//   - word-offset shift applied to the branch immediate
// -----------------------------------------------------------------------------
package branch_resolve_pkg;

  // br_op encodings
  localparam logic [1:0] OP_BEQ  = 2'b00;
  localparam logic [1:0] OP_BNE  = 2'b01;
  localparam logic [1:0] OP_BLEZ = 2'b10;
  localparam logic [1:0] OP_BGTZ = 2'b11;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_EVAL     = 2'b01;
  localparam logic [1:0] ST_REDIRECT = 2'b10;

  // Branch immediate is in words; shift converts it to a byte offset
  localparam int OFFSET_SHIFT = 2;

endpackage

// File: rtl/branch_resolve_target_adder.sv
// -----------------------------------------------------------------------------
// branch_target_adder
// Combinational branch target: pc_plus4 + (sign_extend(imm16) << 2), wrapping
// silently modulo 2^ADDR_W. ADDR_W must be at least 18.
// Ports:
//   pc_plus4  in  ADDR_W  PC of the branch + 4
//   imm16     in  16      signed word offset
//   target    out ADDR_W  branch target address
// -----------------------------------------------------------------------------
module branch_target_adder
  import branch_resolve_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [15:0]       imm16,
  output logic [ADDR_W-1:0] target
);

  logic signed [ADDR_W-1:0] w_ext;
  logic signed [ADDR_W-1:0] w_off;

  assign w_ext  = {{(ADDR_W-16){imm16[15]}}, imm16};
  assign w_off  = w_ext <<< OFFSET_SHIFT;
  assign target = pc_plus4 + $unsigned(w_off);

endmodule

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
// Resolves a conditional branch whose comparison has already been done by the
// ALU (cmp_s[0]). A taken branch pulses flush for one cycle and then offers the
// target to fetch on a valid/ready handshake until accepted.
// Optional feature macro: BRANCH_STATS_EN adds saturating branch / taken-branch
// counters and their output ports.
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   br_valid       in   branch request present
//   br_ready       out  request accepted (IDLE)
//   br_op          in   2-bit branch opcode (debug / statistics only)
//   cmp_s          in   32-bit ALU compare result, only bit 0 is used
//   pc_plus4       in   ADDR_W PC of branch + 4
//   imm16          in   16-bit signed word offset
//   redirect_valid out  target offered to fetch
//   redirect_ready in   fetch accepts target
//   redirect_pc    out  ADDR_W branch target
//   flush          out  one-cycle squash pulse on a taken branch
//   br_count       out  STAT_W (BRANCH_STATS_EN only) resolved branches
//   taken_count    out  STAT_W (BRANCH_STATS_EN only) taken branches
// -----------------------------------------------------------------------------
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int STAT_W = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [1:0]        br_op,
  input  logic [31:0]       cmp_s,
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [15:0]       imm16,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] taken_count
`endif
);

  logic [1:0]        r_state;
  logic [1:0]        r_op;
  logic              r_taken;
  logic [ADDR_W-1:0] r_pc4;
  logic [15:0]       r_imm;
  logic [ADDR_W-1:0] r_redirect_pc;
  logic [ADDR_W-1:0] w_target;
  logic              w_accept;

  assign w_accept = (r_state == ST_IDLE) && br_valid;

  // Request capture: data only, no reset needed since it is only consumed in EVAL
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op    <= br_op;
      r_taken <= cmp_s[0];
      r_pc4   <= pc_plus4;
      r_imm   <= imm16;
    end
  end

  branch_target_adder #(
    .ADDR_W (ADDR_W)
  ) u_target_adder (
    .pc_plus4 (r_pc4),
    .imm16    (r_imm),
    .target   (w_target)
  );

  // FSM and registered target; async reset abandons any pending branch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_redirect_pc <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (br_valid) r_state <= ST_EVAL;
        end
        ST_EVAL: begin
          if (r_taken) begin
            r_state       <= ST_REDIRECT;
            r_redirect_pc <= w_target;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign br_ready       = (r_state == ST_IDLE);
  assign redirect_valid = (r_state == ST_REDIRECT);
  assign redirect_pc    = r_redirect_pc;
  assign flush          = (r_state == ST_EVAL) && r_taken;

  // The ALU has already selected the comparison, so br_op does not affect
  // resolution; it is captured for debug visibility only.
  logic w_unused;
  assign w_unused = ^{cmp_s[31:1], r_op};

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] r_br_cnt;
  logic [STAT_W-1:0] r_tk_cnt;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_br_cnt <= '0;
      r_tk_cnt <= '0;
    end else if (r_state == ST_EVAL) begin
      r_br_cnt <= sat_inc(r_br_cnt);
      if (r_taken) r_tk_cnt <= sat_inc(r_tk_cnt);
    end
  end

  assign br_count    = r_br_cnt;
  assign taken_count = r_tk_cnt;
`else
  logic [STAT_W-1:0] w_unused_stat;
  assign w_unused_stat = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve
// Directed testbench for branch_resolve with hand-computed expected values.
// Statistics checks are included when BRANCH_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int STAT_W = 4;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              reset;
  logic              br_valid;
  logic              br_ready;
  logic [1:0]        br_op;
  logic [31:0]       cmp_s;
  logic [ADDR_W-1:0] pc_plus4;
  logic [15:0]       imm16;
  logic              redirect_valid;
  logic              redirect_ready;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush;
`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] br_count;
  logic [STAT_W-1:0] taken_count;
`endif

  int n_cmp;
  int n_err;

  branch_resolve #(
    .STAT_W (STAT_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_op          (br_op),
    .cmp_s          (cmp_s),
    .pc_plus4       (pc_plus4),
    .imm16          (imm16),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush)
`ifdef BRANCH_STATS_EN
    ,
    .br_count       (br_count),
    .taken_count    (taken_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request so the next rising edge accepts it
  task automatic req(input logic [1:0] op, input logic [31:0] c,
                     input logic [31:0] pc, input logic [15:0] imm);
    br_valid = 1'b1;
    br_op    = op;
    cmp_s    = c;
    pc_plus4 = pc;
    imm16    = imm;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset          = 1'b0;
    br_valid       = 1'b0;
    br_op          = 2'b00;
    cmp_s          = '0;
    pc_plus4       = '0;
    imm16          = '0;
    redirect_ready = 1'b1;

    // Reset state
    step();
    chk("rst_br_ready", {31'd0, br_ready}, 32'd1);
    chk("rst_rvalid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'h0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
`ifdef BRANCH_STATS_EN
    chk("rst_brcnt", {28'd0, br_count}, 32'd0);
    chk("rst_tkcnt", {28'd0, taken_count}, 32'd0);
`endif

    // BEQ taken; accepted on first edge after reset release
    reset = 1'b1;
    req(OP_BEQ, 32'h1, 32'h0040_0004, 16'h0003);
    step();
    br_valid = 1'b0;
    chk("beq_eval_ready", {31'd0, br_ready}, 32'd0);
    chk("beq_eval_flush", {31'd0, flush}, 32'd1);
    chk("beq_eval_rvalid", {31'd0, redirect_valid}, 32'd0);
    step();
    chk("beq_rvalid", {31'd0, redirect_valid}, 32'd1);
    chk("beq_rpc", redirect_pc, 32'h0040_0010);
    chk("beq_flush_off", {31'd0, flush}, 32'd0);
    step();
    chk("beq_idle_ready", {31'd0, br_ready}, 32'd1);
    chk("beq_idle_rvalid", {31'd0, redirect_valid}, 32'd0);

    // BNE not taken; upper cmp_s bits set but ignored
    req(OP_BNE, 32'hFFFF_FFFE, 32'h0000_2000, 16'h0040);
    step();
    br_valid = 1'b0;
    chk("bne_eval_ready", {31'd0, br_ready}, 32'd0);
    chk("bne_eval_flush", {31'd0, flush}, 32'd0);
    step();
    chk("bne_ready_back", {31'd0, br_ready}, 32'd1);
    chk("bne_no_rvalid", {31'd0, redirect_valid}, 32'd0);
    chk("bne_no_flush", {31'd0, flush}, 32'd0);

    // Negative offset wrap-around
    req(OP_BLEZ, 32'h1, 32'h0000_0000, 16'hFFFF);
    step();
    br_valid = 1'b0;
    chk("wrap_flush", {31'd0, flush}, 32'd1);
    step();
    chk("wrap_rvalid", {31'd0, redirect_valid}, 32'd1);
    chk("wrap_rpc", redirect_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_idle", {31'd0, br_ready}, 32'd1);

    // Fetch stalls 5 cycles; new requests during hold are ignored
    redirect_ready = 1'b0;
    req(OP_BGTZ, 32'h1, 32'h0000_1000, 16'h0010);
    step();
    req(OP_BEQ, 32'h1, 32'h0000_8000, 16'h0001);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("hold_rvalid", {31'd0, redirect_valid}, 32'd1);
      chk("hold_rpc", redirect_pc, 32'h0000_1040);
      chk("hold_ready", {31'd0, br_ready}, 32'd0);
      chk("hold_flush", {31'd0, flush}, 32'd0);
      if (i < 4) step();
    end
    redirect_ready = 1'b1;
    br_valid       = 1'b0;
    step();
    chk("hold_release_ready", {31'd0, br_ready}, 32'd1);
    chk("hold_release_rvalid", {31'd0, redirect_valid}, 32'd0);
    step();
    chk("hold_no_extra_eval", {31'd0, flush}, 32'd0);
    chk("hold_still_idle", {31'd0, br_ready}, 32'd1);

    // Reset pulse while in REDIRECT abandons the branch
    redirect_ready = 1'b0;
    req(OP_BEQ, 32'h1, 32'h0000_4000, 16'h0004);
    step();
    br_valid = 1'b0;
    step();
    chk("rr_rvalid_before", {31'd0, redirect_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rr_async_rvalid", {31'd0, redirect_valid}, 32'd0);
    chk("rr_async_rpc", redirect_pc, 32'h0);
    chk("rr_async_ready", {31'd0, br_ready}, 32'd1);
    step();
    reset          = 1'b1;
    redirect_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_no_redirect", {31'd0, redirect_valid}, 32'd0);
      chk("rr_no_flush", {31'd0, flush}, 32'd0);
    end

`ifdef BRANCH_STATS_EN
    // 20 taken branches saturate the 4-bit counters
    for (int i = 0; i < 20; i++) begin
      req(OP_BEQ, 32'h1, 32'h0000_0100, 16'h0001);
      step();
      br_valid = 1'b0;
      step();
      step();
    end
    chk("stat_brcnt_sat", {28'd0, br_count}, 32'd15);
    chk("stat_tkcnt_sat", {28'd0, taken_count}, 32'd15);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
